// File: rtl/ftdi_tx_crc_framer_pkg.sv
// Shared types and constants for the FTDI transmit CRC framer.
package ftdi_tx_crc_framer_pkg;

    // Framer states: no packet open, packet open, CRC beat waiting for a slot.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DATA     = 2'd1,
        ST_CRC_PEND = 2'd2
    } state_e;

    localparam int          CRC_W            = 8;
    localparam logic [7:0]  CRC_INIT_DEFAULT = 8'h00;
    // x^8 + x^2 + x + 1, MSB-first, non-reflected.
    localparam logic [7:0]  CRC_POLY         = 8'h07;

endpackage : ftdi_tx_crc_framer_pkg

// File: rtl/ftdi_tx_crc_framer_crc8.sv
// Combinational CRC-8 step: folds one byte into the running CRC, MSB first.
module crc8_ftdi
    import ftdi_tx_crc_framer_pkg::*;
(
    input  logic [CRC_W-1:0] crc_i,
    input  logic [7:0]       data_i,
    output logic [CRC_W-1:0] crc_o
);

    // stage[0] is the byte already XORed into the register; each later
    // stage is one shift of the polynomial division.
    logic [CRC_W-1:0] stage [0:8];

    assign stage[0] = crc_i ^ data_i;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][CRC_W-1]
                               ? ({stage[gi][CRC_W-2:0], 1'b0} ^ CRC_POLY)
                               :  {stage[gi][CRC_W-2:0], 1'b0};
        end
    endgenerate

    assign crc_o = stage[8];

endmodule : crc8_ftdi

// File: rtl/ftdi_tx_crc_framer.sv
// Packet framer: passes payload bytes through one output register and
// appends a CRC-8 beat (m_last_o=1) after the last byte of each packet.
module ftdi_tx_crc_framer
    import ftdi_tx_crc_framer_pkg::*;
#(
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
    input  logic        m_ready_i,
    output logic [15:0] pkt_cnt_o
);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic             out_free;
    logic             s_ready;
    logic             accept;
    logic [CRC_W-1:0] crc_seed;
    logic [CRC_W-1:0] crc_next;

    // The output register can take a new beat when empty or being drained.
    assign out_free = !m_valid_q || m_ready_i;
    assign s_ready  = (state_q != ST_CRC_PEND) && out_free && !rst;
    assign accept   = s_valid_i && s_ready;

    // A fresh packet always starts from CRC_INIT, whatever crc_q holds.
    assign crc_seed = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

    crc8_ftdi u_crc8 (
        .crc_i  (crc_seed),
        .data_i (s_data_i),
        .crc_o  (crc_next)
    );

    // Next-state, CRC and output-register logic.
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        pkt_cnt_d = pkt_cnt_q;

        if (out_free) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            m_data_d  = s_data_i;
            m_valid_d = 1'b1;
            m_last_d  = 1'b0;
            crc_d     = crc_next;
            state_d   = s_last_i ? ST_CRC_PEND : ST_DATA;
        end else if (state_q == ST_CRC_PEND && out_free) begin
            m_data_d  = crc_q;
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            crc_d     = CRC_INIT;
            state_d   = ST_IDLE;
        end

        // A packet counts as complete once its CRC beat is taken downstream.
        if (m_valid_q && m_ready_i && m_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            crc_q     <= CRC_INIT;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign s_ready_o = s_ready;
    assign m_data_o  = m_data_q;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;
    assign pkt_cnt_o = pkt_cnt_q;

endmodule : ftdi_tx_crc_framer
